// File: rtl/spis_ctrl.sv
// SPI slave controller: oversampled SCK/CS/MOSI, all four SPI modes, TX/RX FIFOs.
// Define SPIS_MSB_FIRST_EN for MSB-first bit order (default is LSB first).
`timescale 1ns/1ps
module spis_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] DUMMY_WORD = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_en,
    input  logic [1:0]            cfg_mode,
    input  logic                  flag_clr,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overflow,
    output logic                  tx_underflow,
    output logic                  busy
);
    // state   | meaning
    // S_IDLE  | wait for CS fall with cfg_en=1, latch mode
    // S_LOAD  | pop TX word (or dummy) into shifter, clear bit counter
    // S_SHIFT | shift/sample on SCK edges until DATA_WIDTH samples
    // S_DONE  | push RX word (or flag overflow), then next word or idle
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [2:0]            r_sck_s;
    logic [1:0]            r_cs_s, r_mosi_s;
    logic                  r_cs_d;
    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_cpol, r_cpha;
    logic [DATA_WIDTH-1:0] r_tx_sh, r_rx_sh;
    logic                  r_miso, r_oe, r_ovf, r_unf;

    logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic [AW:0]           r_tx_cnt, r_rx_cnt;
    logic [DATA_WIDTH-1:0] r_rx_data;

    logic w_sck_rise, w_sck_fall, w_lead, w_trail, w_sample, w_shift;
    logic w_cs_act, w_cs_fall, w_mosi;
    logic w_load, w_done, w_tx_nempty, w_rx_full;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic [AW-1:0]         w_rx_rd_nxt;
    logic [DATA_WIDTH-1:0] w_tx_word, w_tx_shifted, w_sh_next, w_rx_next;
    logic                  w_tx_first, w_sh_first;

    assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
    assign w_sck_fall = ~r_sck_s[1] & r_sck_s[2];
    assign w_lead     = r_cpol ? w_sck_fall : w_sck_rise;
    assign w_trail    = r_cpol ? w_sck_rise : w_sck_fall;
    assign w_sample   = r_cpha ? w_trail : w_lead;
    assign w_shift    = r_cpha ? w_lead : w_trail;
    assign w_cs_act   = ~r_cs_s[1];
    assign w_cs_fall  = w_cs_act & r_cs_d;
    assign w_mosi     = r_mosi_s[1];

    assign w_load      = cfg_en & w_cs_act & (r_state == S_LOAD);
    assign w_done      = cfg_en & w_cs_act & (r_state == S_DONE);
    assign w_tx_nempty = (r_tx_cnt != '0);
    assign w_rx_full   = (r_rx_cnt == DEPTH_C);
    assign w_tx_push   = tx_valid & tx_ready;
    assign w_tx_pop    = w_load & w_tx_nempty;
    assign w_rx_push   = w_done & ~w_rx_full;
    assign w_rx_pop    = rx_ready & rx_valid;
    assign w_rx_rd_nxt = r_rx_rd + AW'(1);
    assign w_tx_word   = w_tx_nempty ? r_tx_mem[r_tx_rd] : DUMMY_WORD;

`ifdef SPIS_MSB_FIRST_EN
    assign w_tx_first   = w_tx_word[DATA_WIDTH-1];
    assign w_tx_shifted = {w_tx_word[DATA_WIDTH-2:0], 1'b0};
    assign w_sh_first   = r_tx_sh[DATA_WIDTH-1];
    assign w_sh_next    = {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
    assign w_rx_next    = {r_rx_sh[DATA_WIDTH-2:0], w_mosi};
`else
    assign w_tx_first   = w_tx_word[0];
    assign w_tx_shifted = {1'b0, w_tx_word[DATA_WIDTH-1:1]};
    assign w_sh_first   = r_tx_sh[0];
    assign w_sh_next    = {1'b0, r_tx_sh[DATA_WIDTH-1:1]};
    assign w_rx_next    = {w_mosi, r_rx_sh[DATA_WIDTH-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_s  <= '0;
            r_cs_s   <= 2'b11;
            r_mosi_s <= '0;
            r_cs_d   <= 1'b1;
        end else begin
            r_sck_s  <= {r_sck_s[1:0], spi_sck};
            r_cs_s   <= {r_cs_s[0], spi_cs_n};
            r_mosi_s <= {r_mosi_s[0], spi_mosi};
            r_cs_d   <= r_cs_s[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_tx_sh <= '0;
            r_rx_sh <= '0;
            r_miso  <= 1'b0;
            r_oe    <= 1'b0;
        end else begin
            r_oe <= cfg_en & w_cs_act & (r_state != S_IDLE);
            if (!cfg_en) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_tx_sh <= '0;
                r_rx_sh <= '0;
                r_miso  <= 1'b0;
            end else if ((r_state != S_IDLE) && !w_cs_act) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_cs_fall) begin
                        {r_cpol, r_cpha} <= cfg_mode;
                        r_state          <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (r_cpha) begin
                            r_tx_sh <= w_tx_word;
                        end else begin
                            r_miso  <= w_tx_first;
                            r_tx_sh <= w_tx_shifted;
                        end
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        // CPHA=0: the trailing edge after the last sample belongs to the
                        // previous word; bit 0 of this word was already driven from LOAD.
                        if (w_shift && (r_cpha || (r_cnt != '0))) begin
                            r_miso  <= w_sh_first;
                            r_tx_sh <= w_sh_next;
                        end
                        if (w_sample) begin
                            r_rx_sh <= w_rx_next;
                            r_cnt   <= r_cnt + CW'(1);
                            if (r_cnt == CW'(DATA_WIDTH - 1))
                                r_state <= S_DONE;
                        end
                    end
                    default: r_state <= S_LOAD;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_unf <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_load && !w_tx_nempty) r_unf <= 1'b1;
            else if (flag_clr)          r_unf <= 1'b0;
            if (w_done && w_rx_full)    r_ovf <= 1'b1;
            else if (flag_clr)          r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= tx_data;
        if (w_rx_push) r_rx_mem[r_rx_wr] <= r_rx_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wr   <= '0;
            r_tx_rd   <= '0;
            r_tx_cnt  <= '0;
            r_rx_wr   <= '0;
            r_rx_rd   <= '0;
            r_rx_cnt  <= '0;
            r_rx_data <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + AW'(1);
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + AW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + (AW+1)'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - (AW+1)'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
            if (w_rx_push) r_rx_wr <= r_rx_wr + AW'(1);
            if (w_rx_pop)  r_rx_rd <= w_rx_rd_nxt;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + (AW+1)'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - (AW+1)'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
            // Head register follows the entry that will be at the read pointer next cycle.
            if (w_rx_pop && (r_rx_cnt > (AW+1)'(1)))
                r_rx_data <= r_rx_mem[w_rx_rd_nxt];
            else if (w_rx_push && ((r_rx_cnt == '0) || w_rx_pop))
                r_rx_data <= r_rx_sh;
        end
    end

    assign spi_miso     = r_miso;
    assign spi_miso_oe  = r_oe;
    assign tx_ready     = (r_tx_cnt != DEPTH_C);
    assign rx_valid     = (r_rx_cnt != '0);
    assign rx_data      = r_rx_data;
    assign rx_overflow  = r_ovf;
    assign tx_underflow = r_unf;
    assign busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_spis_ctrl.sv
// Testbench for spis_ctrl: bench acts as SPI master with random words, checked
// against a queue-based model of the TX/RX FIFOs, frame word loads and sticky flags.
`timescale 1ns/1ps
module tb_spis_ctrl;
    localparam int             DW    = 8;
    localparam int             DEPTH = 4;
    localparam int             H     = 8;
    localparam logic [DW-1:0]  DUMMY = 8'h5A;
`ifdef SPIS_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, cfg_en = 1'b1, flag_clr = 1'b0;
    logic [1:0]    cfg_mode = 2'b00;
    logic          spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic          spi_miso, spi_miso_oe, tx_ready, rx_valid, rx_overflow, tx_underflow, busy;
    logic [DW-1:0] tx_data = '0, rx_data;
    logic          tx_valid = 1'b0, rx_ready = 1'b0;

    int            n_vec = 0, n_err = 0;
    logic [DW-1:0] txq[$], rxq[$];
    bit            m_unf = 1'b0, m_ovf = 1'b0;

    always #5 clk = ~clk;

    spis_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DUMMY_WORD(DUMMY)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .flag_clr(flag_clr),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .tx_underflow(tx_underflow), .busy(busy));

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected summary before 500us");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        if (txq.size() < DEPTH) txq.push_back(w);
        check("tx_ready", tx_ready, txq.size() < DEPTH);
    endtask

    // Each word slot of a frame loads one TX word; the slot opened after the last
    // completed word (CS still low at DONE) is consumed as well.
    task automatic model_load(output logic [DW-1:0] w);
        if (txq.size() > 0) w = txq.pop_front();
        else begin
            w     = DUMMY;
            m_unf = 1'b1;
        end
    endtask

    task automatic half_wait(input bit meas);
        int lat;
        lat = -1;
        for (int i = 1; i <= H; i++) begin
            tick(1);
            if (meas && rx_valid === 1'b1 && lat < 0) lat = i;
        end
        if (meas) check("rx_valid_latency", (lat >= 1 && lat <= 5), 1);
    endtask

    task automatic frame(input logic [1:0] mode, input int nw, input int abort_bits, input bit meas);
        logic [DW-1:0] exp_tx[$];
        logic [DW-1:0] w, mi, mo;
        bit            cpol, cpha, aborted;
        int            lat, nloads, idx;
        cpol    = mode[1];
        cpha    = mode[0];
        aborted = 1'b0;
        nloads  = (abort_bits > 0) ? 1 : nw + 1;
        for (int k = 0; k < nloads; k++) begin
            model_load(w);
            exp_tx.push_back(w);
        end
        cfg_mode = mode;
        spi_sck  = cpol;
        tick(4);
        spi_cs_n = 1'b0;
        lat = -1;
        for (int i = 1; i <= H; i++) begin
            tick(1);
            if (spi_miso_oe === 1'b1 && lat < 0) lat = i;
        end
        if (meas) check("oe_latency", (lat >= 1 && lat <= 5), 1);
        else      check("oe_active", spi_miso_oe, 1'b1);
        for (int wi = 0; wi < nw; wi++) begin
            mi = DW'($urandom);
            mo = '0;
            for (int b = 0; b < DW; b++) begin
                if (abort_bits > 0 && b == abort_bits) begin
                    aborted = 1'b1;
                    break;
                end
                idx = MSB ? DW - 1 - b : b;
                if (!cpha) begin
                    spi_mosi = mi[idx];
                    tick(H);
                    mo[idx]  = spi_miso;
                    spi_sck  = ~cpol;
                    half_wait(meas && wi == 0 && b == DW - 1);
                    spi_sck  = cpol;
                end else begin
                    spi_sck  = ~cpol;
                    spi_mosi = mi[idx];
                    tick(H);
                    mo[idx]  = spi_miso;
                    spi_sck  = cpol;
                    half_wait(meas && wi == 0 && b == DW - 1);
                end
            end
            if (aborted) break;
            check($sformatf("miso_word m%0d w%0d", mode, wi), mo, exp_tx[wi]);
            if (rxq.size() < DEPTH) rxq.push_back(mi);
            else m_ovf = 1'b1;
        end
        tick(H);
        spi_cs_n = 1'b1;
        tick(2 * H);
    endtask

    task automatic drain();
        while (rxq.size() > 0) begin
            check("rx_valid", rx_valid, 1'b1);
            check("rx_data", rx_data, rxq.pop_front());
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
        check("rx_empty", rx_valid, 1'b0);
    endtask

    task automatic check_flags();
        check("tx_underflow", tx_underflow, m_unf);
        check("rx_overflow", rx_overflow, m_ovf);
    endtask

    task automatic clear_flags();
        flag_clr = 1'b1;
        tick(1);
        flag_clr = 1'b0;
        m_unf    = 1'b0;
        m_ovf    = 1'b0;
        check_flags();
    endtask

    initial begin
        logic [1:0] mode;
        int         nw, np;

        tick(3);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_oe", spi_miso_oe, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, '0);
        check("rst_flags", {rx_overflow, tx_underflow}, 2'b00);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick(3);

        // mode 0, one word with latency measurements
        push(8'hA5);
        frame(2'b00, 1, 0, 1'b1);
        check_flags();
        drain();
        clear_flags();

        // modes 1..3, two-word frames
        for (int m = 1; m < 4; m++) begin
            push(DW'($urandom));
            push(DW'($urandom));
            frame(2'(m), 2, 0, 1'b0);
            check("busy_idle", busy, 1'b0);
            check_flags();
            drain();
            clear_flags();
        end

        // empty TX FIFO sends the dummy word
        frame(2'b00, 1, 0, 1'b0);
        check_flags();
        drain();
        clear_flags();

        // fill TX FIFO
        for (int i = 0; i < DEPTH; i++) push(DW'($urandom));
        frame(2'b11, 3, 0, 1'b0);
        check_flags();
        drain();
        clear_flags();

        // RX overflow: five words with nothing popped
        frame(2'b00, 5, 0, 1'b0);
        check("tx_ready_ovf", tx_ready, 1'b1);
        check_flags();
        drain();
        clear_flags();

        // abort after 3 bits, next frame uses the following TX word
        push(DW'($urandom));
        push(DW'($urandom));
        frame(2'b00, 1, 3, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_no_rx", rx_valid, 1'b0);
        frame(2'b00, 1, 0, 1'b0);
        check_flags();
        drain();
        clear_flags();

        // random frames
        for (int it = 0; it < 6; it++) begin
            mode = 2'($urandom_range(0, 3));
            nw   = $urandom_range(1, 3);
            np   = $urandom_range(0, 3);
            for (int i = 0; i < np && txq.size() < DEPTH; i++) push(DW'($urandom));
            frame(mode, nw, 0, 1'b0);
            check_flags();
            drain();
            clear_flags();
        end

        // disabled block ignores CS; TX FIFO contents survive
        push(8'h80);
        cfg_en   = 1'b0;
        spi_cs_n = 1'b0;
        tick(2 * H);
        check("dis_busy", busy, 1'b0);
        check("dis_oe", spi_miso_oe, 1'b0);
        spi_cs_n = 1'b1;
        tick(4);
        cfg_en = 1'b1;
        tick(4);
        frame(2'b00, 1, 0, 1'b0);
        check_flags();

        // async reset mid-frame with RX data pending and a flag set
        push(DW'($urandom));
        spi_sck  = 1'b0;
        cfg_mode = 2'b00;
        spi_cs_n = 1'b0;
        tick(2 * H);
        spi_sck = 1'b1;
        tick(H);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_miso", spi_miso, 1'b0);
        check("ar_oe", spi_miso_oe, 1'b0);
        check("ar_tx_ready", tx_ready, 1'b1);
        check("ar_rx_valid", rx_valid, 1'b0);
        check("ar_rx_data", rx_data, '0);
        check("ar_flags", {rx_overflow, tx_underflow}, 2'b00);
        check("ar_busy", busy, 1'b0);
        txq.delete();
        rxq.delete();
        m_unf    = 1'b0;
        m_ovf    = 1'b0;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        push(8'h80);
        frame(2'b00, 1, 0, 1'b0);
        check_flags();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spis_ctrl.md
# spis_ctrl

Synthesizable, parametrised SPI slave controller for the MCU peripheral subsystem, the RTL successor to the behavioural SPI slave testbench model. It oversamples the external SCK/CS/MOSI pins in the system clock domain and supports all four SPI modes. Words are a configurable DATA_WIDTH, carried over back-to-back frames with TX and RX FIFOs of configurable depth. The bus-side register wrapper drives the valid/ready FIFO ports.

## Interface
- DATA_WIDTH, 8: bits per SPI word, 4..32.
- FIFO_DEPTH, 4: entries per TX and RX FIFO, power of 2, ≥2.
- DUMMY_WORD, 0: word shifted out when the TX FIFO is empty at a word boundary.
- clk  in  1  system clock; SCK frequency must be ≤ clk/8.
- rst_n  in  1  asynchronous active-low reset.
- cfg_en  in  1  block enable; 0 holds the FSM in IDLE and tri-states MISO.
- cfg_mode  in  2  {CPOL,CPHA}; sampled only at CS assertion.
- flag_clr  in  1  one-cycle pulse; clears rx_overflow and tx_underflow.
- spi_sck, spi_cs_n, spi_mosi  in  1 each  asynchronous pad inputs.
- spi_miso  out  1  serial data out.
- spi_miso_oe  out  1  pad output enable; 1 only while CS is active and cfg_en=1.
- tx_data  in  DATA_WIDTH  word to transmit.
- tx_valid  in  1  push request; tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_WIDTH  head of RX FIFO; rx_valid  out  1  RX FIFO not empty; rx_ready  in  1  pop.
- rx_overflow, tx_underflow  out  1 each  sticky error flags.
- busy  out  1  high while the FSM is not in IDLE.

## Operation
- Each of sck/cs_n/mosi passes through a 2-flop synchronizer. A 3rd flop on sck feeds rise/fall edge detection.
- Edge roles: the leading edge is rising for CPOL=0, falling for CPOL=1.
  - CPHA=0: sample MOSI on the leading edge, shift MISO on the trailing edge; bit 0 is presented at CS assertion.
  - CPHA=1: shift MISO on the leading edge (bit 0 at the first leading edge), sample on the trailing edge.
- Bit order is LSB first by default (see Configuration).
- FSM states:
  - IDLE: waits for synced CS falling with cfg_en=1; latches cfg_mode → LOAD.
  - LOAD: one cycle; pops the TX FIFO into the shift register, or loads DUMMY_WORD and sets tx_underflow if the FIFO is empty; clears the bit counter → SHIFT.
  - SHIFT: counts sample edges; at sample DATA_WIDTH completes the word → DONE.
  - DONE: one cycle; pushes the RX word into the RX FIFO, or drops it and sets rx_overflow if the FIFO is full → LOAD if CS is still active, else IDLE.
- CS rising in any state → IDLE on the next cycle. A partial RX word is discarded. A partially sent TX word is consumed, not retried. The bit counter clears.
- For CPHA=0 multi-word frames, the first bit of the next word is driven from LOAD, before the next leading edge.
- FIFOs: binary pointers with log2(FIFO_DEPTH)+1-bit count.
  - Push on valid&ready and an internal pop may occur in the same cycle; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_data is the registered head entry, valid whenever rx_valid=1.
- Sticky flags:
  - Set has priority over flag_clr in the same cycle.
  - cfg_en=0 forces IDLE, resets bit counter and shift registers, and preserves FIFO contents.

## Timing
- Reset values: spi_miso 0, spi_miso_oe 0, tx_ready 1, rx_valid 0, rx_data 0, rx_overflow 0, tx_underflow 0, busy 0; FSM IDLE; FIFOs empty.
- Pin edge to internal edge pulse: 3 clk. MISO update: registered, 4 clk after the SCK shift edge. This fits within a half SCK period at clk/8.
- CS fall to spi_miso_oe=1 and the first bit valid (CPHA=0): 5 clk (sync 3, IDLE→LOAD 1, register 1).
- Last sample edge to rx_valid=1: 5 clk (3 sync, DONE 1, FIFO write 1).
- tx_ready deasserts in the cycle after the push that fills the FIFO. rx_valid deasserts in the cycle after the pop that empties it.

## Configuration
- SPIS_MSB_FIRST_EN defined: bit DATA_WIDTH-1 is shifted first on MISO, and received bits enter at the LSB, shifting left.
- Undefined: LSB first, matching the existing slave model; received bits fill from bit 0 upward.

## Test plan
- Mode 0, DATA_WIDTH=8: push 0xA5, master sends 0x3C in one 8-clock frame → MISO bit stream 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid=1 within 5 clk of the last edge.
- Modes 1/2/3, DATA_WIDTH=16: push 0x1234 then 0xBEEF, one 32-clock frame with MOSI 0xCAFE,0x0F0F → MISO returns both words in order; RX FIFO holds 0xCAFE then 0x0F0F.
- TX empty, DUMMY_WORD=0x5A → MISO sends 0x5A; tx_underflow=1 until a flag_clr pulse, then 0.
- FIFO_DEPTH=4, rx_ready=0, master sends 5 words → first 4 are retained; the 5th is dropped; rx_overflow=1; tx_ready stays 1.
- CS deasserted after 3 of 8 bits → no RX push; busy=0 after 4 clk. The next frame transmits the next TX FIFO word, not the aborted one.
- rst_n low mid-frame → all outputs at reset values asynchronously; FIFOs empty. With SPIS_MSB_FIRST_EN, a 0x80 push sends 1 first.
